free_list_queue: RTL and testbench
==================================

// Module: free_list_queue
// PURPOSE
// - Parametrised circular-queue free list for the int or fp PRF in rename.
// - Replaces the bitmap/priority-scan allocator: O(1) per-lane allocation from head, release to tail.
// - Checkpoints only the head pointer, so branch recovery restores all speculatively allocated regs in 1 cycle.
// - Used by the rename stage (alloc) and the ROB commit path (release).
// PARAMETERS
// - PRF_SIZE      64  physical registers; power of 2; queue depth = PRF_SIZE
// - ALLOC_WIDTH    4  rename lanes requesting one preg each per cycle
// - FREE_WIDTH     4  commit lanes returning one preg each per cycle
// - CP_NUM         4  checkpoint slots
// - Derived: IDX_W=$clog2(PRF_SIZE); PTR_W=IDX_W+1 (MSB = wrap bit); CP_W=$clog2(CP_NUM)
// PORTS
// - clock          in   1                  rising-edge clock
// - reset          in   1                  synchronous, active-high
// - alloc_req      in   ALLOC_WIDTH        lane i requests a preg
// - alloc_preg     out  ALLOC_WIDTH*IDX_W  lane i granted preg; valid when alloc_req[i] & alloc_ready
// - alloc_ready    out  1                  enough free regs for all requested lanes this cycle
// - free_valid     in   FREE_WIDTH         lane j returns free_preg[j]
// - free_preg      in   FREE_WIDTH*IDX_W   preg being returned; must never be 0
// - check          in   1                  take checkpoint into slot check_idx
// - check_idx      in   CP_W               checkpoint slot written
// - recover        in   1                  restore head from slot recover_idx
// - recover_idx    in   CP_W               checkpoint slot read
// - free_count     out  IDX_W+1            entries currently in queue (registered)
// - err_double_free out 1                  sticky; see CONFIGURATION
// BEHAVIOUR
// - Reset: queue[k]=k+1 for k=0..PRF_SIZE-2; head=0; tail=PRF_SIZE-1; free_count=PRF_SIZE-1.
// - Reset: every checkpoint slot = 0; err_double_free=0. Preg 0 never enters the queue.
// - count = tail-head (PTR_W arithmetic, wraps naturally); n_req = popcount(alloc_req).
// - alloc_ready = !recover & (n_req <= count); combinational, 0 latency.
// - Alloc grants are compacted: the k-th set bit of alloc_req gets queue[(head+k) mod PRF_SIZE].
// - Alloc grant table: lanes with alloc_req[i]=0 drive 0; all-or-nothing; no partial grant.
// - Alloc fire (alloc_ready & n_req!=0): head <= head+n_req at clock edge.
// - Release: free lanes compacted in lane order; queue[tail+m] <= m-th valid free_preg; tail += popcount.
// - Release is always accepted, including in recover and stall cycles; the queue cannot overflow.
// - This holds because at most PRF_SIZE-1 pregs circulate.
// - Same-cycle alloc and release: allocation sees the pre-edge count only; released regs are allocatable next cycle.
// - Checkpoint: if check & !recover, cp[check_idx] <= head_next (head after this cycle's alloc).
// - The branch's own destination therefore survives recovery.
// - Recover: head <= cp[recover_idx]; tail still advances by this cycle's releases; alloc suppressed.
// - Recover with check in the same cycle: recover wins; the check write is dropped.
// - Full/empty: count==0 with n_req==0 gives alloc_ready=1. Wrap-around uses the MSB wrap bit.
// - free_count updates one cycle after the fire, release or recover that changes it.
// CONFIGURATION
// - FREELIST_DUP_CHECK_EN defined: add a PRF_SIZE-bit in-queue bitmap, set on release and cleared on alloc.
// - On recover, the bitmap is rebuilt from queue entries in [cp_head, tail).
// - Releasing a preg already marked, or preg 0, sets err_double_free (sticky until reset).
// - Undefined: no bitmap; err_double_free tied to 0.
// TESTING
// - Reset, alloc_req=4'b1111 -> alloc_preg={4,3,2,1} (lane3..0), alloc_ready=1; next cycle free_count=59.
// - alloc_req=4'b1010 -> lane1=p1, lane3=p2, lanes0/2 = 0; head advances by 2.
// - Drain to count=2, request 3 -> alloc_ready=0, head unchanged.
// - Same drained state, release p5 in the same cycle -> next cycle a 3-lane request is granted.
// - Alloc p1..p4, check slot1 same cycle, alloc p5..p8, then recover slot1 -> next alloc returns p5 first.
// - Release p9 during that recover cycle -> p9 is queued at the tail.
// - 200 cycles of random alloc/free with tail wrap -> no duplicate grant and count consistent with a scoreboard.
// - With FREELIST_DUP_CHECK_EN, free p7 twice -> err_double_free=1 on the next cycle and stays 1.

Source files
------------

// File: rtl/free_list_queue.sv
// rtl/free_list_queue.sv - circular-queue physical register free list with head checkpoints
//
// Purpose:
//   Free list for the int or fp PRF used by rename. Free pregs live in a
//   circular queue. Rename lanes allocate from the head. Commit lanes release
//   to the tail. Only the head pointer is checkpointed, so branch recovery
//   restores every speculatively allocated preg in a single cycle.
//   Optional macro FREELIST_DUP_CHECK_EN adds an in-queue bitmap that flags
//   double frees and releases of preg 0 on err_double_free.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   alloc_req       per-lane allocation request
//   alloc_preg      per-lane granted preg (lane i at [i*IDX_W +: IDX_W]); 0 on idle lanes
//   alloc_ready     enough free pregs for every requesting lane (combinational)
//   free_valid      per-lane release strobe
//   free_preg       per-lane released preg
//   check           take a checkpoint of the post-allocation head into check_idx
//   check_idx       checkpoint slot written
//   recover         restore head from recover_idx; suppresses allocation
//   recover_idx     checkpoint slot read
//   free_count      registered number of queued pregs
//   err_double_free sticky duplicate-release flag (0 unless FREELIST_DUP_CHECK_EN)

module free_list_queue #(
  parameter int PRF_SIZE    = 64,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int CP_NUM      = 4,
  localparam int IDX_W = $clog2(PRF_SIZE),
  localparam int PTR_W = IDX_W + 1,
  localparam int CP_W  = $clog2(CP_NUM)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ALLOC_WIDTH-1:0]       alloc_req,
  output logic [ALLOC_WIDTH*IDX_W-1:0] alloc_preg,
  output logic                         alloc_ready,
  input  logic [FREE_WIDTH-1:0]        free_valid,
  input  logic [FREE_WIDTH*IDX_W-1:0]  free_preg,
  input  logic                         check,
  input  logic [CP_W-1:0]              check_idx,
  input  logic                         recover,
  input  logic [CP_W-1:0]              recover_idx,
  output logic [IDX_W:0]               free_count,
  output logic                         err_double_free
);

  logic [IDX_W-1:0] queue [PRF_SIZE];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cp [CP_NUM];

  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] n_req;
  logic [PTR_W-1:0] n_free;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic             fire;

  // Rank of each set lane among the set lanes below it; this compacts
  // sparse requests/releases onto consecutive queue slots.
  logic [IDX_W-1:0] alloc_rank [ALLOC_WIDTH];
  logic [IDX_W-1:0] free_rank  [FREE_WIDTH];
  logic [IDX_W-1:0] free_idx   [FREE_WIDTH];

  always_comb begin
    n_req = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_rank[i] = n_req[IDX_W-1:0];
      n_req         = n_req + PTR_W'(alloc_req[i]);
    end
  end

  always_comb begin
    n_free = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      free_rank[j] = n_free[IDX_W-1:0];
      free_idx[j]  = tail[IDX_W-1:0] + n_free[IDX_W-1:0];
      n_free       = n_free + PTR_W'(free_valid[j]);
    end
  end

  // Pointers carry an extra wrap bit, so tail-head gives the exact occupancy
  // even when the queue is completely full or empty.
  assign count       = tail - head;
  assign alloc_ready = !recover && (n_req <= count);
  assign fire        = alloc_ready && (n_req != '0);
  assign head_next   = recover ? cp[recover_idx] : (fire ? head + n_req : head);
  assign tail_next   = tail + n_free;

  always_comb begin
    logic [IDX_W-1:0] idx;
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      idx = head[IDX_W-1:0] + alloc_rank[i];
      alloc_preg[i*IDX_W +: IDX_W] = alloc_req[i] ? queue[idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Entry PRF_SIZE-1 truncates to 0 and sits outside [head, tail),
      // so preg 0 is never handed out.
      for (int k = 0; k < PRF_SIZE; k++) begin
        queue[k] <= IDX_W'(k + 1);
      end
      for (int c = 0; c < CP_NUM; c++) begin
        cp[c] <= '0;
      end
      head       <= '0;
      tail       <= PTR_W'(PRF_SIZE - 1);
      free_count <= PTR_W'(PRF_SIZE - 1);
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (free_valid[j]) begin
          queue[free_idx[j]] <= free_preg[j*IDX_W +: IDX_W];
        end
      end
      head       <= head_next;
      tail       <= tail_next;
      free_count <= tail_next - head_next;
      // head_next already includes this cycle's allocation, so the
      // branch's own destination survives a later recovery.
      if (check && !recover) begin
        cp[check_idx] <= head_next;
      end
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [PRF_SIZE-1:0] in_q;
  logic [PRF_SIZE-1:0] in_q_next;
  logic                dup_hit;
  logic                err_q;

  always_comb begin
    logic [PTR_W-1:0]    cp_head;
    logic [IDX_W-1:0]    offset;
    logic [IDX_W-1:0]    p;
    logic [PRF_SIZE-1:0] rel_seen;
    cp_head   = cp[recover_idx];
    offset    = '0;
    p         = '0;
    rel_seen  = '0;
    dup_hit   = 1'b0;
    in_q_next = in_q;
    if (recover) begin
      // Rebuild from the live window [cp_head, tail) of the queue.
      in_q_next = '0;
      for (int k = 0; k < PRF_SIZE; k++) begin
        offset = IDX_W'(k) - cp_head[IDX_W-1:0];
        if ({1'b0, offset} < (tail - cp_head)) begin
          in_q_next[queue[k]] = 1'b1;
        end
      end
    end else if (fire) begin
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
        if (alloc_req[i]) begin
          in_q_next[alloc_preg[i*IDX_W +: IDX_W]] = 1'b0;
        end
      end
    end
    for (int j = 0; j < FREE_WIDTH; j++) begin
      if (free_valid[j]) begin
        p = free_preg[j*IDX_W +: IDX_W];
        if (p == '0 || in_q[p] || rel_seen[p]) begin
          dup_hit = 1'b1;
        end
        rel_seen[p]  = 1'b1;
        in_q_next[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_q  <= {{(PRF_SIZE-1){1'b1}}, 1'b0};
      err_q <= 1'b0;
    end else begin
      in_q <= in_q_next;
      if (dup_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_double_free = err_q;
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_queue.sv
// tb/tb_free_list_queue.sv - directed and scoreboarded bench for free_list_queue

module tb_free_list_queue;

  logic        clock;
  logic        reset;
  logic [3:0]  alloc_req;
  logic [23:0] alloc_preg;
  logic        alloc_ready;
  logic [3:0]  free_valid;
  logic [23:0] free_preg;
  logic        check;
  logic [1:0]  check_idx;
  logic        recover;
  logic [1:0]  recover_idx;
  logic [6:0]  free_count;
  logic        err_double_free;

  int checks = 0;
  int errors = 0;

  free_list_queue dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_preg     (alloc_preg),
    .alloc_ready    (alloc_ready),
    .free_valid     (free_valid),
    .free_preg      (free_preg),
    .check          (check),
    .check_idx      (check_idx),
    .recover        (recover),
    .recover_idx    (recover_idx),
    .free_count     (free_count),
    .err_double_free(err_double_free)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req   = '0;
    free_valid  = '0;
    free_preg   = '0;
    check       = 1'b0;
    check_idx   = '0;
    recover     = 1'b0;
    recover_idx = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (free_count !== 7'd63) begin
      errors++; $display("FAIL reset_free_count: got %0d expected 63", free_count);
    end
    checks++;
    if (err_double_free !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %0b expected 0", err_double_free);
    end
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_idle: got %0b expected 1", alloc_ready);
    end
  endtask

  task automatic test_alloc_all();
    do_reset();
    alloc_req = 4'b1111;
    #1;
    checks++;
    if (alloc_preg !== {6'd4, 6'd3, 6'd2, 6'd1}) begin
      errors++; $display("FAIL alloc_all_grant: got %h expected %h", alloc_preg, {6'd4, 6'd3, 6'd2, 6'd1});
    end
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL alloc_all_ready: got %0b expected 1", alloc_ready);
    end
    tick();
    idle();
    checks++;
    if (free_count !== 7'd59) begin
      errors++; $display("FAIL alloc_all_count: got %0d expected 59", free_count);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    alloc_req = 4'b1010;
    #1;
    checks++;
    if (alloc_preg !== {6'd2, 6'd0, 6'd1, 6'd0}) begin
      errors++; $display("FAIL sparse_grant: got %h expected %h", alloc_preg, {6'd2, 6'd0, 6'd1, 6'd0});
    end
    tick();
    alloc_req = 4'b0001;
    #1;
    checks++;
    if (free_count !== 7'd61) begin
      errors++; $display("FAIL sparse_count: got %0d expected 61", free_count);
    end
    checks++;
    if (alloc_preg !== {6'd0, 6'd0, 6'd0, 6'd3}) begin
      errors++; $display("FAIL sparse_head_adv: got %h expected %h", alloc_preg, {6'd0, 6'd0, 6'd0, 6'd3});
    end
    idle();
  endtask

  task automatic test_stall_and_release();
    do_reset();
    alloc_req = 4'b1111;
    for (int c = 0; c < 15; c++) tick();
    alloc_req = 4'b0001;
    tick();
    alloc_req = 4'b0111;
    #1;
    checks++;
    if (free_count !== 7'd2) begin
      errors++; $display("FAIL drain_count: got %0d expected 2", free_count);
    end
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready: got %0b expected 0", alloc_ready);
    end
    tick();
    alloc_req = 4'b0011;
    #1;
    checks++;
    if (free_count !== 7'd2) begin
      errors++; $display("FAIL stall_count: got %0d expected 2", free_count);
    end
    checks++;
    if (alloc_preg !== {6'd0, 6'd0, 6'd63, 6'd62} || alloc_ready !== 1'b1) begin
      errors++; $display("FAIL stall_head_kept: got %h/%0b expected %h/1", alloc_preg, alloc_ready, {6'd0, 6'd0, 6'd63, 6'd62});
    end
    alloc_req  = 4'b0111;
    free_valid = 4'b0001;
    free_preg  = {6'd0, 6'd0, 6'd0, 6'd5};
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL release_same_cycle_ready: got %0b expected 0", alloc_ready);
    end
    tick();
    free_valid = '0;
    free_preg  = '0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_preg !== {6'd0, 6'd5, 6'd63, 6'd62}) begin
      errors++; $display("FAIL release_next_grant: got %h/%0b expected %h/1", alloc_preg, alloc_ready, {6'd0, 6'd5, 6'd63, 6'd62});
    end
    tick();
    alloc_req = 4'b0000;
    #1;
    checks++;
    if (free_count !== 7'd0 || alloc_ready !== 1'b1) begin
      errors++; $display("FAIL empty_idle_ready: got %0d/%0b expected 0/1", free_count, alloc_ready);
    end
    alloc_req = 4'b0001;
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL empty_req_ready: got %0b expected 0", alloc_ready);
    end
    idle();
  endtask

  task automatic test_checkpoint_recover();
    do_reset();
    alloc_req = 4'b1111;
    check     = 1'b1;
    check_idx = 2'd1;
    tick();
    check = 1'b0;
    #1;
    checks++;
    if (alloc_preg !== {6'd8, 6'd7, 6'd6, 6'd5}) begin
      errors++; $display("FAIL cp_second_grant: got %h expected %h", alloc_preg, {6'd8, 6'd7, 6'd6, 6'd5});
    end
    tick();
    recover     = 1'b1;
    recover_idx = 2'd1;
    check       = 1'b1;
    check_idx   = 2'd2;
    free_valid  = 4'b0001;
    free_preg   = {6'd0, 6'd0, 6'd0, 6'd9};
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL recover_suppress: got %0b expected 0", alloc_ready);
    end
    tick();
    idle();
    alloc_req = 4'b0001;
    #1;
    checks++;
    if (free_count !== 7'd60) begin
      errors++; $display("FAIL recover_count: got %0d expected 60", free_count);
    end
    checks++;
    if (alloc_preg !== {6'd0, 6'd0, 6'd0, 6'd5}) begin
      errors++; $display("FAIL recover_first_grant: got %h expected %h", alloc_preg, {6'd0, 6'd0, 6'd0, 6'd5});
    end
    tick();
    alloc_req = 4'b1111;
    for (int c = 0; c < 14; c++) tick();
    alloc_req = 4'b0111;
    #1;
    checks++;
    if (alloc_preg !== {6'd0, 6'd9, 6'd63, 6'd62}) begin
      errors++; $display("FAIL recover_tail_p9: got %h expected %h", alloc_preg, {6'd0, 6'd9, 6'd63, 6'd62});
    end
    tick();
    idle();
    #1;
    checks++;
    if (free_count !== 7'd0) begin
      errors++; $display("FAIL wrap_count: got %0d expected 0", free_count);
    end
    recover     = 1'b1;
    recover_idx = 2'd2;
    tick();
    idle();
    alloc_req = 4'b0001;
    #1;
    checks++;
    if (alloc_preg !== {6'd0, 6'd0, 6'd0, 6'd1}) begin
      errors++; $display("FAIL recover_beats_check: got %h expected %h", alloc_preg, {6'd0, 6'd0, 6'd0, 6'd1});
    end
    idle();
  endtask

  task automatic test_random();
    int fifo[$];
    int used[$];
    int granted[$];
    int nreq;
    int pick;
    int exp_p;
    logic exp_ready;
    do_reset();
    for (int p = 1; p < 64; p++) fifo.push_back(p);
    for (int cyc = 0; cyc < 200; cyc++) begin
      idle();
      granted.delete();
      alloc_req = 4'($urandom_range(0, 15));
      nreq = $countones(alloc_req);
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 1) == 1 && used.size() > 0) begin
          pick = $urandom_range(0, used.size() - 1);
          free_valid[j] = 1'b1;
          free_preg[j*6 +: 6] = 6'(used[pick]);
          used.delete(pick);
        end
      end
      #1;
      exp_ready = (nreq <= fifo.size());
      checks++;
      if (alloc_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %0b expected %0b", cyc, alloc_ready, exp_ready);
      end
      if (exp_ready) begin
        for (int i = 0; i < 4; i++) begin
          if (alloc_req[i]) begin
            exp_p = fifo.pop_front();
            granted.push_back(exp_p);
            checks++;
            if (alloc_preg[i*6 +: 6] !== 6'(exp_p)) begin
              errors++; $display("FAIL rand_grant cyc %0d lane %0d: got %0d expected %0d", cyc, i, alloc_preg[i*6 +: 6], exp_p);
            end
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (free_valid[j]) fifo.push_back(int'(free_preg[j*6 +: 6]));
      end
      foreach (granted[g]) used.push_back(granted[g]);
      tick();
      checks++;
      if (free_count !== 7'(fifo.size())) begin
        errors++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, free_count, fifo.size());
      end
    end
    idle();
  endtask

  task automatic test_double_free();
`ifdef FREELIST_DUP_CHECK_EN
    do_reset();
    alloc_req = 4'b1111;
    tick();
    tick();
    idle();
    free_valid = 4'b0001;
    free_preg  = {6'd0, 6'd0, 6'd0, 6'd7};
    tick();
    checks++;
    if (err_double_free !== 1'b0) begin
      errors++; $display("FAIL dup_first_free: got %0b expected 0", err_double_free);
    end
    tick();
    idle();
    checks++;
    if (err_double_free !== 1'b1) begin
      errors++; $display("FAIL dup_second_free: got %0b expected 1", err_double_free);
    end
    tick();
    tick();
    tick();
    checks++;
    if (err_double_free !== 1'b1) begin
      errors++; $display("FAIL dup_sticky: got %0b expected 1", err_double_free);
    end
`else
    checks++;
    if (err_double_free !== 1'b0) begin
      errors++; $display("FAIL err_tied_low: got %0b expected 0", err_double_free);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alloc_all();
    test_sparse();
    test_stall_and_release();
    test_checkpoint_recover();
    test_random();
    test_double_free();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
